// File: rtl/avr_uart_rx_monitor.sv
// 8N1 UART receiver for the AVR model's TXD line, buffering bytes in a small FWFT FIFO
// that is drained through a valid/ready handshake. Frame errors and overflow are sticky.
module avr_uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  input  logic               rd_ready,
  input  logic               clr_flags,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy,
  output logic               frame_error,
  output logic               overflow
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [CntW-1:0]  HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FullCount = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              sync1_q, rxs_q, rxs_d_q;
  logic              push, fe_set;

  logic [7:0]        mem [Depth];
  logic [FIFO_AW:0]  wp_q, rp_q;
  logic              full, pop, wr_en, ovf_set;
  logic              fe_q, ovf_q;

  // Synchronizer plus one extra stage for falling-edge detection; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      rxs_d_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
      rxs_d_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (rxs_d_q && !rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            fe_set  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        // Wait out a held-low line so it cannot look like a fresh start bit.
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fifo_count = wp_q - rp_q;
  assign full       = (fifo_count == FullCount);
  assign rd_valid   = (fifo_count != '0);
  assign pop        = rd_valid && rd_ready;
  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign wr_en      = push && (!full || pop);
  assign ovf_set    = push && full && !pop;
  assign rd_data    = rd_valid ? mem[rp_q[FIFO_AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q[FIFO_AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      fe_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (pop)   rp_q <= rp_q + 1'b1;
      fe_q  <= fe_set  || (fe_q  && !clr_flags);
      ovf_q <= ovf_set || (ovf_q && !clr_flags);
    end
  end

  assign busy        = (state_q != StIdle);
  assign frame_error = fe_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_avr_uart_rx_monitor.sv
// Randomized bench for avr_uart_rx_monitor: a queue-based model of the byte stream and FIFO
// occupancy is checked every cycle, plus directed timing, error and reset scenarios.
module tb_avr_uart_rx_monitor;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Aw  = 3;
  localparam int unsigned Depth = 2 ** Aw;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic          rd_ready;
  logic          clr_flags;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [Aw:0]   fifo_count;
  logic          busy;
  logic          frame_error;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  logic [7:0] model_q [$];
  bit         exp_ovf = 1'b0;
  bit         mon_en = 1'b0;
  bit         stream_chk = 1'b0;
  bit         rnd_done = 1'b0;

  avr_uart_rx_monitor #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_AW     (Aw)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rd_ready   (rd_ready),
    .clr_flags  (clr_flags),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_error(frame_error),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: every cycle the occupancy equals the queue length; each accepted pop yields the head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(fifo_count), 32'(model_q.size()));
      check("valid", 32'(rd_valid), 32'(model_q.size() != 0));
      if (stream_chk) check("stream_count_le1", 32'(fifo_count <= 1), 32'd1);
      if (rd_ready && model_q.size() != 0) begin
        check("pop_data", 32'(rd_data), 32'(model_q.pop_front()));
        n_pop++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; the byte reaches the FIFO at the 155th edge after the start.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(Cpb);
    end
    rxd = stop_ok;
    tick(11);
    if (stop_ok) begin
      if (model_q.size() < Depth) model_q.push_back(b);
      else exp_ovf = 1'b1;
    end
    tick(Cpb - 11);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 4 * Depth && rd_valid; i++) tick(1);
    check("drain_done", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(rd_data),     32'd0);
    check({tag, "_valid"}, 32'(rd_valid),    32'd0);
    check({tag, "_count"}, 32'(fifo_count),  32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_fe"},    32'(frame_error), 32'd0);
    check({tag, "_ovf"},   32'(overflow),    32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int pops_before;
    rst_n = 1'b0;
    rxd = 1'b1;
    rd_ready = 1'b0;
    clr_flags = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Single byte with exact arrival cycle.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        tick(154);
        check("lat_pre_valid", 32'(rd_valid), 32'd0);
        tick(1);
        check("lat_valid", 32'(rd_valid), 32'd1);
        check("lat_data", 32'(rd_data), 32'hA5);
        check("lat_count", 32'(fifo_count), 32'd1);
      end
    join
    check("single_fe", 32'(frame_error), 32'd0);
    check("single_ovf", 32'(overflow), 32'd0);
    drain();

    // Short glitch: START entered, then rejected at mid-bit.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    tick(20);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_fe", 32'(frame_error), 32'd0);

    // Stop bit low, line kept low: frame error and BREAK hold.
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("break_busy", 32'(busy), 32'd1);
    check("fe_set", 32'(frame_error), 32'd1);
    check("fe_count", 32'(fifo_count), 32'd0);
    rxd = 1'b1;
    tick(6);
    check("break_exit", 32'(busy), 32'd0);
    pulse_clr();
    check("fe_clr", 32'(frame_error), 32'd0);

    // Nine bytes into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    check("ovf_count", 32'(fifo_count), 32'(Depth));
    check("ovf_flag", 32'(overflow), 32'(exp_ovf));
    check("ovf_head", 32'(rd_data), 32'h01);
    drain();
    pulse_clr();
    check("ovf_clr", 32'(overflow), 32'd0);

    // Pop coinciding with push, then a 20-byte stream with rd_ready held.
    a = 8'($urandom);
    b = 8'($urandom);
    send_frame(a, 1'b1);
    fork
      send_frame(b, 1'b1);
      begin
        tick(154);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
      end
    join
    check("coinc_count", 32'(fifo_count), 32'd1);
    check("coinc_head", 32'(rd_data), 32'(b));
    check("coinc_ovf", 32'(overflow), 32'd0);
    pops_before = n_pop;
    stream_chk = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(8'($urandom), 1'b1);
    tick(4);
    stream_chk = 1'b0;
    rd_ready = 1'b0;
    check("stream_pops", 32'(n_pop - pops_before), 32'd21);
    check("stream_ovf", 32'(overflow), 32'd0);

    // Random consumer pacing and random gaps between frames.
    fork
      begin
        while (!rnd_done) begin
          rd_ready = ($urandom_range(0, 3) == 0);
          tick(1);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          send_frame(8'($urandom), 1'b1);
          tick($urandom_range(1, 20));
        end
        rnd_done = 1'b1;
      end
    join
    check("rand_ovf", 32'(overflow), 32'(exp_ovf));
    drain();
    pulse_clr();

    // Reset during data bit 4 of 0x55 with two bytes buffered.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    a = 8'h55;
    rxd = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 4; i++) begin
      rxd = a[i];
      tick(Cpb);
    end
    rxd = a[4];
    tick(Cpb / 2);
    rst_n = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_all_zero("midrst");
    rxd = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'hAA, 1'b1);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_data", 32'(rd_data), 32'hAA);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
